// File: rtl/space_key_pacer.sv
// Space-key front end for the bouncing position counter: synchronizes and
// debounces the key, toggles run/hold on each accepted press, and paces inc.
module space_key_pacer #(
    parameter int DB_CYC = 1000000,
    parameter int DIV    = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic inc,
    output logic key_pulse,
    output logic running,
    output logic key_level
);

    localparam int DBW = $clog2(DB_CYC + 1);
    localparam int PW  = $clog2(DIV + 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYC - 1);
    localparam logic [PW-1:0]  P_LAST  = PW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} state_t;

    state_t          state_q, state_d;
    logic [DBW-1:0]  db_cnt_q, db_cnt_d;
    logic [PW-1:0]   pcnt_q, pcnt_d;
    logic            s1_q, key_s_q;
    logic            inc_q, inc_d;
    logic            kp_q, kp_d;
    logic            run_q, run_d;
    logic            press_acc;

    // Two-flop synchronizer; key_raw is asynchronous to clk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q    <= 1'b0;
            key_s_q <= 1'b0;
        end else begin
            s1_q    <= key_raw;
            key_s_q <= s1_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            db_cnt_q <= '0;
            pcnt_q   <= '0;
            inc_q    <= 1'b0;
            kp_q     <= 1'b0;
            run_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            db_cnt_q <= db_cnt_d;
            pcnt_q   <= pcnt_d;
            inc_q    <= inc_d;
            kp_q     <= kp_d;
            run_q    <= run_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        db_cnt_d  = db_cnt_q;
        press_acc = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_s_q) begin
                    state_d  = PRESS_CHK;
                    db_cnt_d = '0;
                end
            end
            PRESS_CHK: begin
                if (!key_s_q) begin
                    state_d = IDLE;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d   = HELD;
                    press_acc = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!key_s_q) begin
                    state_d  = REL_CHK;
                    db_cnt_d = '0;
                end
            end
            REL_CHK: begin
                // A high sample here is release bounce: back to HELD, no pulse.
                if (key_s_q) begin
                    state_d = HELD;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d = IDLE;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A stop toggle on the wrap edge must win, so press_acc forces pcnt/inc to 0.
    always_comb begin
        kp_d  = press_acc;
        run_d = run_q ^ press_acc;
        if (!run_q || press_acc) begin
            pcnt_d = '0;
            inc_d  = 1'b0;
        end else if (pcnt_q == P_LAST) begin
            pcnt_d = '0;
            inc_d  = 1'b1;
        end else begin
            pcnt_d = pcnt_q + 1'b1;
            inc_d  = 1'b0;
        end
    end

    assign inc       = inc_q;
    assign key_pulse = kp_q;
    assign running   = run_q;
    assign key_level = (state_q == HELD) || (state_q == REL_CHK);

endmodule
